// File: rtl/branch_resolve_tracker.sv
// branch_resolve_tracker: carries branch predictions through ID/EX, flags mispredicts with a
// zero-latency flush and redirect, pulses predictor updates and keeps saturating statistics.
module branch_resolve_tracker #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             if_valid,
    input  logic             if_is_branch,
    input  logic             if_predict_taken,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             ex_resolve,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_is_branch,
    output logic             upd_taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             proto_err
);
    logic             id_v_q, id_br_q, id_pred_q, ex_v_q, ex_br_q, ex_pred_q;
    logic [XLEN-1:0]  id_pc_q, ex_pc_q;
    logic             id_v_d, ex_v_d;
    logic             upd_br_q, upd_tk_q, upd_br_d, upd_tk_d, perr_q, perr_d;
    logic [CNT_W-1:0] br_cnt_q, mis_cnt_q, br_cnt_d, mis_cnt_d;
    logic             res, mis, bad;
    always_comb begin
        res         = ex_resolve & ~stall & ex_v_q & ex_br_q;
        mis         = res & (ex_pred_q != ex_taken);
        bad         = ex_resolve & ~stall & ~(ex_v_q & ex_br_q);
        flush       = mis;
        redirect_pc = mis ? (ex_taken ? ex_target : ex_pc_q + XLEN'(4)) : '0;
        // a mispredict squashes the younger IF and ID instructions; EX itself retires
        id_v_d      = stall ? id_v_q : if_valid & ~mis;
        ex_v_d      = stall ? ex_v_q : id_v_q & ~mis;
        upd_br_d    = res;
        upd_tk_d    = res ? ex_taken : upd_tk_q;
        br_cnt_d    = (res && br_cnt_q != '1) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
        mis_cnt_d   = (mis && mis_cnt_q != '1) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
        perr_d      = perr_q | bad;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_v_q    <= 1'b0;
            id_br_q   <= 1'b0;
            id_pred_q <= 1'b0;
            id_pc_q   <= '0;
            ex_v_q    <= 1'b0;
            ex_br_q   <= 1'b0;
            ex_pred_q <= 1'b0;
            ex_pc_q   <= '0;
            upd_br_q  <= 1'b0;
            upd_tk_q  <= 1'b0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            id_v_q    <= id_v_d;
            ex_v_q    <= ex_v_d;
            upd_br_q  <= upd_br_d;
            upd_tk_q  <= upd_tk_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            perr_q    <= perr_d;
            if (!stall) begin
                id_br_q   <= if_is_branch;
                id_pred_q <= if_predict_taken;
                id_pc_q   <= if_pc;
                ex_br_q   <= id_br_q;
                ex_pred_q <= id_pred_q;
                ex_pc_q   <= id_pc_q;
            end
        end
    end
    assign upd_is_branch    = upd_br_q;
    assign upd_taken        = upd_tk_q;
    assign branch_count     = br_cnt_q;
    assign mispredict_count = mis_cnt_q;
    assign proto_err        = perr_q;
endmodule

// File: tb/tb_branch_resolve_tracker.sv
// tb_branch_resolve_tracker: directed vector table plus randomized run against a reference model;
// a second instance with 2-bit counters exercises counter saturation.
module tb_branch_resolve_tracker;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stall = 0, if_valid = 0, if_is_branch = 0, if_predict_taken = 0;
    logic [31:0] if_pc = '0, ex_target = '0;
    logic        ex_resolve = 0, ex_taken = 0;
    logic        flush, upd_is_branch, upd_taken, proto_err;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;
    logic        s_flush, s_upd_is_branch, s_upd_taken, s_proto_err;
    logic [31:0] s_redirect_pc;
    logic [1:0]  s_branch_count, s_mispredict_count;
    int applied = 0, miscompares = 0;

    branch_resolve_tracker #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .if_valid(if_valid), .if_is_branch(if_is_branch),
        .if_predict_taken(if_predict_taken), .if_pc(if_pc), .ex_resolve(ex_resolve),
        .ex_taken(ex_taken), .ex_target(ex_target), .flush(flush), .redirect_pc(redirect_pc),
        .upd_is_branch(upd_is_branch), .upd_taken(upd_taken), .branch_count(branch_count),
        .mispredict_count(mispredict_count), .proto_err(proto_err));

    branch_resolve_tracker #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .if_valid(if_valid), .if_is_branch(if_is_branch),
        .if_predict_taken(if_predict_taken), .if_pc(if_pc), .ex_resolve(ex_resolve),
        .ex_taken(ex_taken), .ex_target(ex_target), .flush(s_flush), .redirect_pc(s_redirect_pc),
        .upd_is_branch(s_upd_is_branch), .upd_taken(s_upd_taken), .branch_count(s_branch_count),
        .mispredict_count(s_mispredict_count), .proto_err(s_proto_err));

    always #5 clk = ~clk;

    typedef struct {
        logic st, iv, ib, ip; logic [31:0] pc; logic er, et; logic [31:0] tg;
        logic fl; logic [31:0] rp; logic ub, ut; int bc, mc; logic pe;
    } vec_t;
    typedef struct { bit v, br, pred; logic [31:0] pc; } ins_t;

    vec_t tbl[21];
    ins_t id_m, ex_m;
    int   bc_m, mc_m;
    bit   ub_m, ut_m, pe_m;

    function automatic int sat(int v, int m);
        return v > m ? m : v;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        applied++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    task automatic cmp_all(logic fl, logic [31:0] rp, logic ub, logic ut, int bc, int mc, logic pe);
        chk("flush", 32'(flush), 32'(fl));
        chk("redirect_pc", redirect_pc, rp);
        chk("upd_is_branch", 32'(upd_is_branch), 32'(ub));
        chk("upd_taken", 32'(upd_taken), 32'(ut));
        chk("branch_count", 32'(branch_count), 32'(sat(bc, 65535)));
        chk("mispredict_count", 32'(mispredict_count), 32'(sat(mc, 65535)));
        chk("proto_err", 32'(proto_err), 32'(pe));
        chk("sat_flush", 32'(s_flush), 32'(fl));
        chk("sat_redirect_pc", s_redirect_pc, rp);
        chk("sat_upd", {30'd0, s_upd_is_branch, s_upd_taken}, {30'd0, ub, ut});
        chk("sat_branch_count", 32'(s_branch_count), 32'(sat(bc, 3)));
        chk("sat_mispredict_count", 32'(s_mispredict_count), 32'(sat(mc, 3)));
        chk("sat_proto_err", 32'(s_proto_err), 32'(pe));
    endtask

    task automatic drive(logic st, logic iv, logic ib, logic ip, logic [31:0] pc,
                         logic er, logic et, logic [31:0] tg);
        stall = st; if_valid = iv; if_is_branch = ib; if_predict_taken = ip; if_pc = pc;
        ex_resolve = er; ex_taken = et; ex_target = tg;
    endtask

    task automatic model_reset();
        id_m = '{0, 0, 0, 32'd0}; ex_m = '{0, 0, 0, 32'd0};
        bc_m = 0; mc_m = 0; ub_m = 0; ut_m = 0; pe_m = 0;
    endtask

    initial begin
        //            st iv ib ip pc        er et tg        fl rp        ub ut bc mc pe
        tbl[0]  = '{0, 1, 1, 0, 32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 32'h104, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 32'h108, 1, 1, 32'h200, 1, 32'h200, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 1, 32'h40,  0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 1, 0};
        tbl[4]  = '{0, 1, 1, 1, 32'h80,  0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 32'h0,   1, 0, 32'h999, 1, 32'h44,  0, 1, 1, 1, 0};
        tbl[6]  = '{0, 1, 1, 1, 32'h300, 0, 0, 32'h0,   0, 32'h0,   1, 0, 2, 2, 0};
        tbl[7]  = '{0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 2, 2, 0};
        tbl[8]  = '{0, 0, 0, 0, 32'h0,   1, 1, 32'h500, 0, 32'h0,   0, 0, 2, 2, 0};
        tbl[9]  = '{0, 1, 1, 0, 32'h600, 0, 0, 32'h0,   0, 32'h0,   1, 1, 3, 2, 0};
        tbl[10] = '{0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 3, 2, 0};
        tbl[11] = '{1, 1, 1, 1, 32'h900, 1, 1, 32'h700, 0, 32'h0,   0, 1, 3, 2, 0};
        tbl[12] = '{1, 1, 1, 1, 32'h900, 1, 1, 32'h700, 0, 32'h0,   0, 1, 3, 2, 0};
        tbl[13] = '{1, 1, 1, 1, 32'h900, 1, 1, 32'h700, 0, 32'h0,   0, 1, 3, 2, 0};
        tbl[14] = '{0, 0, 0, 0, 32'h0,   1, 1, 32'h700, 1, 32'h700, 0, 1, 3, 2, 0};
        tbl[15] = '{0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 1, 4, 3, 0};
        tbl[16] = '{0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   0, 1, 4, 3, 0};
        tbl[17] = '{0, 1, 0, 0, 32'h10,  0, 0, 32'h0,   0, 32'h0,   0, 1, 4, 3, 1};
        tbl[18] = '{0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 4, 3, 1};
        tbl[19] = '{0, 0, 0, 0, 32'h0,   1, 1, 32'h20,  0, 32'h0,   0, 1, 4, 3, 1};
        tbl[20] = '{0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 4, 3, 1};

        repeat (2) @(negedge clk);
        #1 cmp_all(0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].st, tbl[i].iv, tbl[i].ib, tbl[i].ip, tbl[i].pc, tbl[i].er, tbl[i].et, tbl[i].tg);
            #1 cmp_all(tbl[i].fl, tbl[i].rp, tbl[i].ub, tbl[i].ut, tbl[i].bc, tbl[i].mc, tbl[i].pe);
        end

        // asynchronous reset mid-sequence, with a branch heading into the pipe
        @(negedge clk);
        drive(0, 1, 1, 0, 32'h123, 1, 1, 32'h456);
        rst_n = 1'b0;
        #1 cmp_all(0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int c = 0; c < 4000; c++) begin
            logic st, iv, ib, ip, er, et;
            logic [31:0] pc, tg, rp;
            bit   res, mis, hit;
            if (c != 0) @(negedge clk);
            if (c % 900 == 450) begin
                rst_n = 1'b0;
                #1 cmp_all(0, 32'h0, 0, 0, 0, 0, 0);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end
            hit = ex_m.v && ex_m.br;
            st  = ($urandom % 6) == 0;
            iv  = ($urandom % 5) != 0;
            ib  = ($urandom % 5) < 3;
            ip  = $urandom % 2;
            pc  = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            er  = hit ? (($urandom % 8) != 0) : (($urandom % 40) == 0);
            et  = $urandom % 2;
            tg  = $urandom & 32'hFFFF_FFFC;
            drive(st, iv, ib, ip, pc, er, et, tg);
            res = er && !st && hit;
            mis = res && (ex_m.pred != et);
            rp  = !mis ? 32'h0 : et ? tg : ex_m.pc + 32'd4;
            #1 cmp_all(mis, rp, ub_m, ut_m, bc_m, mc_m, pe_m);
            @(posedge clk);
            ub_m = res;
            if (res) begin ut_m = et; bc_m++; end
            if (mis) mc_m++;
            if (er && !st && !hit) pe_m = 1;
            if (!st) begin
                ex_m   = id_m;
                ex_m.v = id_m.v && !mis;
                id_m   = '{iv && !mis, ib, ip, pc};
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_resolve_tracker.md
# branch_resolve_tracker

Tracks each fetched instruction's branch prediction through the ID and EX stages of the pipelined RISC core. In EX it compares the prediction with the resolved outcome, raises a flush with the corrected PC on a mispredict, and drives the registered update pulse (`is_branch`, `prev_taken`) back into the 2-bit predictor. It also keeps saturating branch and mispredict counters for performance monitoring.

## Interface
- `XLEN`, 32: PC/target width.
- `CNT_W`, 16: width of the statistics counters.

- `clk` input 1: core clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: pipeline hold. Tracker registers keep their contents and no resolution occurs.
- `if_valid` input 1: an instruction is leaving IF this cycle.
- `if_is_branch` input 1: the IF instruction is a conditional branch.
- `if_predict_taken` input 1: the predictor's output for this IF instruction.
- `if_pc` input XLEN: PC of the IF instruction.
- `ex_resolve` input 1: the EX branch unit has resolved a branch this cycle.
- `ex_taken` input 1: the actual outcome, valid with `ex_resolve`.
- `ex_target` input XLEN: the taken target, valid with `ex_resolve`.
- `flush` output 1: combinational mispredict flush.
- `redirect_pc` output XLEN: combinational correct next PC, valid with `flush`.
- `upd_is_branch` output 1: registered predictor update strobe.
- `upd_taken` output 1: registered actual outcome, valid with `upd_is_branch`.
- `branch_count` output CNT_W: number of resolved branches, saturating.
- `mispredict_count` output CNT_W: number of mispredicts, saturating.
- `proto_err` output 1: sticky flag, set when `ex_resolve` arrives for a non-branch or empty EX slot.

## Operation
- Two tracker slots:
  - ID slot: `id_v`, `id_br`, `id_pred`, `id_pc`.
  - EX slot: `ex_v`, `ex_br`, `ex_pred`, `ex_pc`.
- Advance when `stall`=0 (one rising edge):
  - The ID slot loads `if_*`, with `id_v` = `if_valid & ~flush`.
  - The EX slot loads the ID slot, with `ex_v` = `id_v & ~flush`.
- When `stall`=1, both slots hold. `flush` is forced to 0 and no counter or update activity occurs.
- Resolve event: `res` = `ex_resolve & ~stall & ex_v & ex_br`.
- Mispredict: `mis` = `res & (ex_pred != ex_taken)`.
- `flush` = `mis`.
  - `redirect_pc` = `ex_taken ? ex_target : ex_pc + 4`. Addition is modulo 2^XLEN, so it wraps at the top of the address space.
  - When `flush`=0, `redirect_pc` = 0.
- When `flush` is 1, the IF instruction and the ID slot are both squashed (their valids clear at the edge). The EX slot itself completes normally.
- Predictor update: at the edge where `res`=1, `upd_is_branch` is set to 1 and `upd_taken` to `ex_taken`. Otherwise `upd_is_branch` goes to 0. `upd_taken` holds its last value.
- Counters:
  - `branch_count` increments on `res`.
  - `mispredict_count` increments on `mis`.
  - Each saturates at all-ones (2^CNT_W−1) and never wraps.
- `proto_err` sets on `ex_resolve & ~stall & ~(ex_v & ex_br)`. It clears only on reset. The offending `ex_resolve` is otherwise ignored: no flush, no update, no count.
- A correctly predicted branch produces an update pulse and a `branch_count` increment, and no flush.

## Timing
- Reset (async assert, any cycle) clears:
  - all slot valids;
  - `upd_is_branch`, `upd_taken`, both counters and `proto_err`, all to 0.
- While the slots are empty, `flush`=0 and `redirect_pc`=0.
- Latency from IF to EX: an instruction accepted at edge N is in the ID slot after N and in the EX slot after N+1, given no stall.
- `flush`/`redirect_pc` are asserted in the same cycle as `ex_resolve`, with zero latency.
- `upd_is_branch` is asserted for exactly one cycle, the cycle after `res`. The predictor sees the new counter state from the cycle after that.
- A stall cycle extends every slot's residency by one cycle.
- Back-to-back resolves on consecutive cycles give consecutive update pulses and count correctly.
- Reset deasserted mid-operation: the tracker restarts empty. Any in-flight `ex_resolve` in the first cycle after deassertion raises `proto_err`.

## Test plan
- Taken branch at PC 0x100 with prediction 0, resolved with `ex_taken`=1 and `ex_target`=0x200 -> `flush`=1, `redirect_pc`=0x200, the ID slot is squashed, next cycle `upd_is_branch`=1/`upd_taken`=1, and `mispredict_count`=1, `branch_count`=1.
- Branch at PC 0x40 with prediction 1, resolved not-taken -> `flush`=1, `redirect_pc`=0x44, `upd_taken`=0.
- Branch with prediction 1, resolved taken -> `flush`=0, `upd_is_branch` pulses once, `branch_count`+1, `mispredict_count` unchanged.
- `stall` held 3 cycles with a branch in EX and `ex_resolve`=1 -> no flush and no counts during the stall. Resolution happens on the first non-stall cycle.
- Preload both counters to 0xFFFE, then 3 mispredicts -> both counters stop at 0xFFFF.
- `ex_resolve` with a non-branch in EX -> `proto_err`=1 and stays set, with no flush and no update. Assert `rst_n`=0 mid-sequence -> all outputs 0 immediately.
